// File: rtl/checkpoint_latency_monitor.sv
// Watches firmware checkpoint words, times each A5->5A FIR run and grades the session pass/fail.
// Optional session timeout is enabled by defining CHKMON_TIMEOUT_EN.
module checkpoint_latency_monitor #(
  parameter int NUM_TESTS   = 3,
  parameter int TIMEOUT_CYC = 1500000,
  parameter int CNT_W       = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [15:0]      checkbits_i,
  output logic [2:0]       state_o,
  output logic [3:0]       test_idx_o,
  output logic [CNT_W-1:0] latency_o,
  output logic             latency_valid_o,
  output logic [CNT_W-1:0] total_latency_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_RUN        = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_PASS       = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cur_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W:0]   total_sum;
  logic [3:0]       idx_q, idx_d;
  logic             lat_vld_q, lat_vld_d;

  logic ev, la_start, run_start, run_end, la_done;

  // Events fire only on the cycle the registered word changes.
  assign ev        = (cur_q != prev_q);
  assign la_start  = ev && (cur_q == 16'hAB40);
  assign run_start = ev && (cur_q[7:0] == 8'hA5);
  assign run_end   = ev && (cur_q[7:0] == 8'h5A);
  assign la_done   = ev && (cur_q == 16'hAB51);

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign total_sum = {1'b0, total_q} + {1'b0, cnt_inc};

`ifdef CHKMON_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    lat_vld_d = 1'b0;
    total_d   = total_q;
    idx_d     = idx_q;

    case (state_q)
      S_IDLE: if (la_start) state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (run_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (run_start) begin
          cnt_d = '0;
        end else if (run_end) begin
          // Reported latency counts the cycle in which the end marker lands.
          lat_d     = cnt_inc;
          lat_vld_d = 1'b1;
          total_d   = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
          idx_d     = idx_q + 4'd1;
          state_d   = (idx_d < 4'(NUM_TESTS)) ? S_WAIT_START : S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (la_done) state_d = S_PASS;
      default: ;
    endcase

    if (la_done && (state_q inside {S_IDLE, S_WAIT_START, S_RUN}))
      state_d = S_FAIL;

`ifdef CHKMON_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (state_q != S_PASS && state_q != S_FAIL) begin
      to_cnt_d = to_cnt_q + 1'b1;
      // Timeout overrides whatever event landed this cycle.
      if (to_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
        state_d   = S_FAIL;
        timeout_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      lat_vld_q <= 1'b0;
      total_q   <= '0;
      idx_q     <= '0;
`ifdef CHKMON_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= checkbits_i;
      prev_q    <= cur_q;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      lat_vld_q <= lat_vld_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
`ifdef CHKMON_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign state_o         = state_q;
  assign test_idx_o      = idx_q;
  assign latency_o       = lat_q;
  assign latency_valid_o = lat_vld_q;
  assign total_latency_o = total_q;
  assign pass_o          = (state_q == S_PASS);
  assign fail_o          = (state_q == S_FAIL);
`ifdef CHKMON_TIMEOUT_EN
  assign timeout_o       = timeout_q;
`else
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_checkpoint_latency_monitor.sv
// Directed bench for checkpoint_latency_monitor; define CHKMON_TIMEOUT_EN to exercise the timeout build.
module tb_checkpoint_latency_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] chk = 16'h0000;
  logic [2:0]  state;
  logic [3:0]  idx;
  logic [31:0] lat, total;
  logic        lat_vld, pass, fail, tmo;

  int tests = 0;
  int fails = 0;

  checkpoint_latency_monitor #(
    .NUM_TESTS(3), .TIMEOUT_CYC(1000), .CNT_W(32)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .checkbits_i(chk),
    .state_o(state), .test_idx_o(idx), .latency_o(lat),
    .latency_valid_o(lat_vld), .total_latency_o(total),
    .pass_o(pass), .fail_o(fail), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Drive one A5->5A run of n cycles and check the result two edges later.
  task automatic do_run(input int n, input int exp_idx, input int exp_total, input int exp_state);
    chk = 16'h00A5;
    tick(n);
    chk = 16'h005A;
    tick(2);
    chk_eq("run_latency", lat, n);
    chk_eq("run_valid_hi", {31'd0, lat_vld}, 1);
    chk_eq("run_idx", {28'd0, idx}, exp_idx);
    chk_eq("run_total", total, exp_total);
    chk_eq("run_state", {29'd0, state}, exp_state);
    tick(1);
    chk_eq("run_valid_lo", {31'd0, lat_vld}, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_eq("rst_state", {29'd0, state}, 0);
    chk_eq("rst_idx", {28'd0, idx}, 0);
    chk_eq("rst_lat", lat, 0);
    chk_eq("rst_total", total, 0);
    chk_eq("rst_flags", {29'd0, pass, fail, tmo}, 0);

    // Nominal session: 100/200/300
    chk = 16'hAB40;
    tick(2);
    chk_eq("nom_wait_start", {29'd0, state}, 1);
    do_run(100, 1, 100, 1);
    do_run(200, 2, 300, 1);
    do_run(300, 3, 600, 3);
    chk = 16'hAB51;
    tick(2);
    chk_eq("nom_state_pass", {29'd0, state}, 4);
    chk_eq("nom_flags", {29'd0, pass, fail, tmo}, 3'b100);
    chk = 16'hAB40;
    tick(3);
    chk_eq("nom_terminal", {29'd0, state}, 4);

    // Held A5 marker does not retrigger
    do_reset();
    chk = 16'hAB40;
    tick(2);
    chk = 16'h00A5;
    tick(50);
    chk_eq("held_state_run", {29'd0, state}, 2);
    chk_eq("held_idx0", {28'd0, idx}, 0);
    tick(70);
    chk = 16'h005A;
    tick(2);
    chk_eq("held_latency", lat, 120);
    chk_eq("held_idx1", {28'd0, idx}, 1);

    // Early AB51 after one run
    do_reset();
    chk = 16'hAB40;
    tick(2);
    do_run(50, 1, 50, 1);
    chk = 16'hAB51;
    tick(2);
    chk_eq("early_state_fail", {29'd0, state}, 5);
    chk_eq("early_flags", {29'd0, pass, fail, tmo}, 3'b010);

    // Timeout: A5 with no 5A
    do_reset();
    chk = 16'hAB40;
    tick(2);
    chk = 16'h00A5;
    tick(2);
    tick(995);
    chk_eq("to_before_fail", {31'd0, fail}, 0);
    tick(1);
`ifdef CHKMON_TIMEOUT_EN
    chk_eq("to_state_fail", {29'd0, state}, 5);
    chk_eq("to_flags", {29'd0, pass, fail, tmo}, 3'b011);
`else
    chk_eq("to_state_run", {29'd0, state}, 2);
    chk_eq("to_flags", {29'd0, pass, fail, tmo}, 3'b000);
`endif

    // Reset mid-run, then a full session
    do_reset();
    chk = 16'hAB40;
    tick(2);
    do_run(30, 1, 30, 1);
    chk = 16'h01A5;
    tick(51);
    chk_eq("mid_state_run", {29'd0, state}, 2);
    do_reset();
    chk_eq("mid_rst_state", {29'd0, state}, 0);
    chk_eq("mid_rst_outs", {lat[15:0], total[7:0], idx, lat_vld, pass, fail, tmo}, 0);
    chk = 16'hAB40;
    tick(2);
    chk_eq("mid_wait_start", {29'd0, state}, 1);
    do_run(10, 1, 10, 1);
    do_run(20, 2, 30, 1);
    do_run(30, 3, 60, 3);
    chk = 16'hAB51;
    tick(2);
    chk_eq("mid_pass", {29'd0, pass, fail, tmo}, 3'b100);

    // AB40 held across reset release, then restart within RUN
    chk = 16'hAB40;
    do_reset();
    tick(2);
    chk_eq("held_ab40_start", {29'd0, state}, 1);
    chk = 16'h00A5;
    tick(40);
    chk = 16'h01A5;
    tick(70);
    chk = 16'h005A;
    tick(2);
    chk_eq("restart_latency", lat, 70);
    chk_eq("restart_idx", {28'd0, idx}, 1);
    chk_eq("restart_total", total, 70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
